// File: rtl/spi_master_duplex.sv
// Full-duplex SPI master with runtime CPOL/CPHA, bit order and SCK divider.
// One word per valid/ready command; the received word returns as a one-cycle pulse.
module spi_master_duplex #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CS_NUM = 1,
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned CS_W   = (CS_NUM > 1) ? $clog2(CS_NUM) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_cpol,
    input  logic              cfg_cpha,
    input  logic              cfg_lsb_first,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [CS_W-1:0]   cmd_cs,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              sck,
    output logic              mosi,
    input  logic              miso,
    output logic [CS_NUM-1:0] cs_n
);

    localparam int unsigned EDGE_W    = $clog2(2 * DATA_W + 1);
    localparam int unsigned LAST_EDGE = 2 * DATA_W;

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

    state_t            state, state_d;
    logic [DIV_W-1:0]  div_q, div_d, cnt_q, cnt_d, div_m1;
    logic [EDGE_W-1:0] edge_q, edge_d, edge_k;
    logic              cpha_q, cpha_d, lsb_q, lsb_d;
    logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, tx_shift;
    logic [DATA_W-1:0] rsp_data_d;
    logic [CS_NUM-1:0] cs_n_d;
    logic              sck_d, mosi_d, rsp_valid_d, ready_d;

    // Phase length minus one; a zero divider behaves as one.
    assign div_m1 = (cfg_div == '0) ? '0 : cfg_div - DIV_W'(1);

    // Next-state and next-output logic; every SCK edge lands at the end of a D-cycle phase.
    always_comb begin
        state_d     = state;
        div_d       = div_q;
        cnt_d       = cnt_q;
        edge_d      = edge_q;
        cpha_d      = cpha_q;
        lsb_d       = lsb_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        sck_d       = sck;
        mosi_d      = mosi;
        cs_n_d      = cs_n;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data;
        edge_k      = edge_q + EDGE_W'(1);
        tx_shift    = lsb_q ? (tx_q >> 1) : (tx_q << 1);

        unique case (state)
            IDLE: begin
                sck_d  = cfg_cpol;
                mosi_d = 1'b0;
                cs_n_d = '1;
                if (cmd_valid) begin
                    state_d = SETUP;
                    div_d   = div_m1;
                    cnt_d   = div_m1;
                    edge_d  = '0;
                    cpha_d  = cfg_cpha;
                    lsb_d   = cfg_lsb_first;
                    tx_d    = cmd_data;
                    rx_d    = '0;
                    mosi_d  = cfg_cpha ? 1'b0
                            : (cfg_lsb_first ? cmd_data[0] : cmd_data[DATA_W-1]);
                    // Out-of-range index leaves every select deasserted.
                    for (int unsigned i = 0; i < CS_NUM; i++) begin
                        cs_n_d[i] = (32'(cmd_cs) != i);
                    end
                end
            end
            SETUP, XFER: begin
                if (cnt_q == '0) begin
                    cnt_d  = div_q;
                    edge_d = edge_k;
                    sck_d  = ~sck;
                    if (edge_k[0] != cpha_q) begin
                        rx_d = lsb_q ? {miso, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], miso};
                    end
                    if (cpha_q && edge_k[0]) begin
                        mosi_d = lsb_q ? tx_q[0] : tx_q[DATA_W-1];
                        tx_d   = tx_shift;
                    end else if (!cpha_q && !edge_k[0] && (edge_k != EDGE_W'(LAST_EDGE))) begin
                        mosi_d = lsb_q ? tx_shift[0] : tx_shift[DATA_W-1];
                        tx_d   = tx_shift;
                    end
                    state_d = (edge_k == EDGE_W'(LAST_EDGE)) ? HOLD : XFER;
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    cnt_d       = div_q;
                    cs_n_d      = '1;
                    mosi_d      = 1'b0;
                    rsp_data_d  = rx_q;
                    rsp_valid_d = 1'b1;
                    state_d     = GAP;
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            div_q     <= '0;
            cnt_q     <= '0;
            edge_q    <= '0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            sck       <= 1'b0;
            mosi      <= 1'b0;
            cs_n      <= '1;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            edge_q    <= edge_d;
            cpha_q    <= cpha_d;
            lsb_q     <= lsb_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            sck       <= sck_d;
            mosi      <= mosi_d;
            cs_n      <= cs_n_d;
            cmd_ready <= ready_d;
            busy      <= !ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
        end
    end

endmodule
